// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 16x-oversampled UART byte receiver (8N1, or 8E1 when
// UART_RX_PARITY_EN is defined) with a level-valid / ack handshake.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   uart_in      raw asynchronous serial line, idles high
//   rx_data      last delivered byte, stable while rx_valid=1
//   rx_valid     byte available, held until rx_ack
//   rx_ack       consumer accepts the byte (only while rx_valid=1)
//   framing_err  sticky, stop bit sampled low
//   overrun      sticky, byte completed while rx_valid=1 and no ack
//   parity_err   sticky, even-parity mismatch (0 without parity build)
//   busy         receiver not idle
//
// Build option: UART_RX_PARITY_EN adds a PARITY state (8E1 frames).

module uart_rx_byte #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       framing_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);

  localparam int TICK_RATE = BAUD * OVERSAMPLE;
  localparam int TICK_DIV  =
    (CLK_FREQ + TICK_RATE / 2) / TICK_RATE;
  localparam int TW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_MAX =
    TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SAMP_MAX =
    SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] SAMP_HALF =
    SW'(OVERSAMPLE / 2 - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;
`endif

  state_t state_q, state_d;

  logic          sync1_q, sync2_q, prev_q;
  logic          s_in;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  logic [SW-1:0] samp_cnt_q, samp_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          deliver;
  logic          par_ok;

`ifdef UART_RX_PARITY_EN
  logic perr_q, perr_d;
  logic par_bad_q, par_bad_d;
  assign par_ok = ~par_bad_q;
`else
  assign par_ok = 1'b1;
`endif

  assign s_in = sync2_q;
  assign tick = (tick_cnt_q == TICK_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      samp_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q     <= 1'b0;
      par_bad_q  <= 1'b0;
`endif
    end else begin
      sync1_q    <= uart_in;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      samp_cnt_q <= samp_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
`ifdef UART_RX_PARITY_EN
      perr_q     <= perr_d;
      par_bad_q  <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    samp_cnt_d = samp_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    ferr_d     = ferr_q;
    ovr_d      = ovr_q;
    deliver    = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d     = perr_q;
    par_bad_d  = par_bad_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (prev_q && !s_in) begin
          state_d    = S_START;
          samp_cnt_d = '0;
          // Restart the tick phase at the edge.
          tick_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
          par_bad_d  = 1'b0;
`endif
        end
      end

      S_START: begin
        if (tick) begin
          if (samp_cnt_q == SAMP_HALF) begin
            samp_cnt_d = '0;
            if (!s_in) begin
              state_d   = S_DATA;
              bit_idx_d = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          if (samp_cnt_q == SAMP_MAX) begin
            samp_cnt_d = '0;
            shift_d[bit_idx_q] = s_in;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + 1'b1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (samp_cnt_q == SAMP_MAX) begin
            samp_cnt_d = '0;
            state_d    = S_STOP;
            // Even parity: data plus parity bit has an even count.
            if (^{shift_q, s_in}) begin
              par_bad_d = 1'b1;
              perr_d    = 1'b1;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + 1'b1;
          end
        end
      end
`endif

      S_STOP: begin
        if (tick) begin
          if (samp_cnt_q == SAMP_MAX) begin
            samp_cnt_d = '0;
            if (s_in) begin
              // Back to IDLE at mid-stop so the next start
              // edge is caught.
              state_d = S_IDLE;
              deliver = par_ok;
            end else begin
              state_d = S_WAIT_HIGH;
              ferr_d  = 1'b1;
            end
          end else begin
            samp_cnt_d = samp_cnt_q + 1'b1;
          end
        end
      end

      S_WAIT_HIGH: begin
        // Hold off through a break until the line idles.
        if (s_in) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (rx_valid_q && rx_ack) begin
      rx_valid_d = 1'b0;
    end

    if (deliver) begin
      if (!rx_valid_q || rx_ack) begin
        rx_data_d  = shift_q;
        rx_valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign framing_err = ferr_q;
  assign overrun     = ovr_q;
  assign busy        = (state_q != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err  = perr_q;
`else
  assign parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed frames against uart_rx_byte at a
// reduced clock rate (8 clks per tick, 128 clks per bit).

module tb_uart_rx_byte;

  localparam int CLK_FREQ = 1228800;
  localparam int BAUD     = 9600;
  localparam int OS       = 16;
  localparam int BIT      = 128;
  localparam int HALF     = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       framing_err;
  logic       overrun;
  logic       parity_err;
  logic       busy;

  int checks = 0;
  int errors = 0;

`ifdef UART_RX_PARITY_EN
  logic par_flip = 1'b0;
`endif

  uart_rx_byte #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .OVERSAMPLE(OS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_in    (uart_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ack     (rx_ack),
    .framing_err(framing_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic v);
    uart_in = v;
    tick_n(BIT);
  endtask

  // Start bit, data LSB first, and parity in the 8E1 build.
  task automatic send_head(input logic [7:0] b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^b) ^ par_flip);
`endif
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic stop);
    send_head(b);
    drive_bit(stop);
  endtask

  task automatic ack_pulse();
    rx_ack = 1'b1;
    tick_n(1);
    rx_ack = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    tick_n(1);
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    uart_in = 1'b1;
    rx_ack  = 1'b0;
    tick_n(3);
    rst = 1'b0;

    // Idle line after reset.
    tick_n(20000);
    chk("idle_valid", rx_valid, 0);
    chk("idle_busy", busy, 0);
    chk("idle_ferr", framing_err, 0);
    chk("idle_ovr", overrun, 0);
    chk("idle_perr", parity_err, 0);
    chk("idle_data", rx_data, 0);

    // 0x5A: rx_valid rises 3 clks after raw mid-stop.
    send_head(8'h5A);
    uart_in = 1'b1;
    tick_n(HALF + 2);
    chk("lat_early", rx_valid, 0);
    tick_n(1);
    chk("lat_valid", rx_valid, 1);
    chk("lat_data", rx_data, 8'h5A);
    tick_n(BIT - HALF - 3);
    tick_n(1000);
    chk("hold_valid", rx_valid, 1);
    chk("hold_data", rx_data, 8'h5A);
    chk("hold_ovr", overrun, 0);
    ack_pulse();
    chk("ack_valid", rx_valid, 0);
    tick_n(1);
    chk("ack_stay", rx_valid, 0);

    // Back-to-back, no ack: second byte dropped.
    send_frame(8'h31, 1'b1);
    send_frame(8'hC7, 1'b1);
    tick_n(10);
    chk("ovr_data", rx_data, 8'h31);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_flag", overrun, 1);
    ack_pulse();
    pulse_rst();
    tick_n(10);
    chk("ovr_clr", overrun, 0);

    // Back-to-back with ack on the deliver cycle.
    send_frame(8'h31, 1'b1);
    send_head(8'hC7);
    uart_in = 1'b1;
    tick_n(HALF + 2);
    rx_ack = 1'b1;
    tick_n(1);
    rx_ack = 1'b0;
    chk("coin_data", rx_data, 8'hC7);
    chk("coin_valid", rx_valid, 1);
    chk("coin_ovr", overrun, 0);
    tick_n(BIT - HALF - 3);
    ack_pulse();
    chk("coin_ack", rx_valid, 0);

    // Short low glitch on the idle line.
    tick_n(50);
    uart_in = 1'b0;
    tick_n(20);
    chk("gl_busy", busy, 1);
    tick_n(20);
    uart_in = 1'b1;
    tick_n(200);
    chk("gl_idle", busy, 0);
    chk("gl_valid", rx_valid, 0);
    chk("gl_ferr", framing_err, 0);

    // Stop bit low, then a long break.
    send_head(8'hFF);
    uart_in = 1'b0;
    tick_n(BIT);
    tick_n(400);
    chk("brk_ferr", framing_err, 1);
    chk("brk_busy", busy, 1);
    chk("brk_valid", rx_valid, 0);
    uart_in = 1'b1;
    tick_n(5);
    chk("brk_rel", busy, 0);
    tick_n(50);
    send_frame(8'h0D, 1'b1);
    tick_n(5);
    chk("brk_next", rx_data, 8'h0D);
    chk("brk_nval", rx_valid, 1);
    chk("brk_sticky", framing_err, 1);
    ack_pulse();

    // Reset in the middle of 0xA5's data bits.
    tick_n(50);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    uart_in = 1'b1;
    tick_n(HALF);
    chk("rst_pre", busy, 1);
    pulse_rst();
    chk("rst_busy", busy, 0);
    chk("rst_ferr", framing_err, 0);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    tick_n(2000);
    chk("rst_quiet", rx_valid, 0);
    send_frame(8'h42, 1'b1);
    tick_n(5);
    chk("rst_next", rx_data, 8'h42);
    chk("rst_nval", rx_valid, 1);
    ack_pulse();

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: good parity bit is 1.
    tick_n(50);
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    tick_n(5);
    chk("par_valid", rx_valid, 1);
    chk("par_data", rx_data, 8'h07);
    chk("par_ok", parity_err, 0);
    ack_pulse();
    tick_n(50);
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    tick_n(5);
    chk("par_err", parity_err, 1);
    chk("par_drop", rx_valid, 0);
`else
    chk("perr_tied", parity_err, 0);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
